home_actuator_sched: RTL and testbench

Power-channel scheduler that sits between the smart-home control FSM and the actuator drivers. The home controller raises level requests for the front/rear door motors, heater, cooler, window buzzer and fire alarm. This block grants the single shared power channel to at most one load at a time. It enforces a heater/cooler minimum on-time and a changeover lockout, and multiplexes the alarm and window indications onto one buzzer.

---
 rtl/home_actuator_sched_if.sv | 26 ++
 rtl/home_actuator_sched.sv | 167 ++++++++++++++++
 tb/tb_home_actuator_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/home_actuator_sched_if.sv
// Request/drive bundle between the home controller and the power-channel scheduler.
interface home_actuator_sched_if;
    logic       req_fdoor;
    logic       req_rdoor;
    logic       req_heater;
    logic       req_cooler;
    logic       req_alarm;
    logic       req_win;
    logic       drv_fdoor;
    logic       drv_rdoor;
    logic       drv_heater;
    logic       drv_cooler;
    logic       drv_buzz;
    logic       conflict;
    logic [2:0] state;

    modport master (
        output req_fdoor, req_rdoor, req_heater, req_cooler, req_alarm, req_win,
        input  drv_fdoor, drv_rdoor, drv_heater, drv_cooler, drv_buzz, conflict, state
    );

    modport slave (
        input  req_fdoor, req_rdoor, req_heater, req_cooler, req_alarm, req_win,
        output drv_fdoor, drv_rdoor, drv_heater, drv_cooler, drv_buzz, conflict, state
    );
endinterface

// File: rtl/home_actuator_sched.sv
// Grants one shared power channel to door motors or HVAC, with HVAC minimum on-time,
// changeover lockout, and an alarm/window buzzer multiplexer.
module home_actuator_sched #(
    parameter int unsigned MIN_ON     = 8,
    parameter int unsigned LOCKOUT    = 16,
    parameter int unsigned DOOR_PULSE = 4,
    parameter int unsigned BEEP_HALF  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    home_actuator_sched_if.slave bus
);

    localparam int unsigned MaxA = (MIN_ON > LOCKOUT) ? MIN_ON : LOCKOUT;
    localparam int unsigned MaxB = (DOOR_PULSE > BEEP_HALF) ? DOOR_PULSE : BEEP_HALF;
    localparam int unsigned MaxC = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CW   = $clog2(MaxC + 1);

    localparam logic [CW-1:0] MinOnLast = CW'(MIN_ON - 1);
    localparam logic [CW-1:0] LockLast  = CW'(LOCKOUT - 1);
    localparam logic [CW-1:0] DoorLast  = CW'(DOOR_PULSE - 1);
    localparam logic [CW-1:0] BeepLast  = CW'(BEEP_HALF - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFdoor = 3'd1,
        StRdoor = 3'd2,
        StHeat  = 3'd3,
        StCool  = 3'd4,
        StLock  = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic          pend_f_q, pend_f_d;
    logic          pend_r_q, pend_r_d;
    logic          fdoor_q, rdoor_q, win_q, alarm_q;
    logic          buzz_q, buzz_d;
    logic          conflict_q;
    logic          rise_f, rise_r;
    logic          enter_f, enter_r;
    logic          own_req, opp_req;

    assign rise_f  = bus.req_fdoor & ~fdoor_q;
    assign rise_r  = bus.req_rdoor & ~rdoor_q;
    assign own_req = (state_q == StHeat) ? bus.req_heater : bus.req_cooler;
    assign opp_req = (state_q == StHeat) ? bus.req_cooler : bus.req_heater;

    // A new door edge always re-arms the flag, even on the cycle its state is entered.
    assign pend_f_d = rise_f | (pend_f_q & ~enter_f);
    assign pend_r_d = rise_r | (pend_r_q & ~enter_r);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        enter_f = 1'b0;
        enter_r = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (pend_f_q) begin
                    state_d = StFdoor;
                    enter_f = 1'b1;
                end else if (pend_r_q) begin
                    state_d = StRdoor;
                    enter_r = 1'b1;
                end else if (!rise_f && !rise_r && !bus.req_alarm) begin
                    // A door edge in this same cycle outranks HVAC; it is served next cycle.
                    if (bus.req_heater && !bus.req_cooler) begin
                        state_d = StHeat;
                    end else if (bus.req_cooler && !bus.req_heater) begin
                        state_d = StCool;
                    end
                end
            end
            StFdoor, StRdoor: begin
                if (cnt_q == DoorLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHeat, StCool: begin
                if (bus.req_alarm) begin
                    state_d = StLock;
                    cnt_d   = '0;
                end else if (cnt_q == MinOnLast) begin
                    if (!own_req || opp_req || pend_f_q || pend_r_q) begin
                        state_d = StLock;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLock: begin
                if (cnt_q == LockLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Beep pattern restarts high on a window rise or when an alarm releases it.
    always_comb begin
        buzz_d = 1'b0;
        bcnt_d = '0;
        if (bus.req_alarm) begin
            buzz_d = 1'b1;
        end else if (bus.req_win) begin
            if (!win_q || alarm_q) begin
                buzz_d = 1'b1;
            end else if (bcnt_q == BeepLast) begin
                buzz_d = ~buzz_q;
            end else begin
                buzz_d = buzz_q;
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bcnt_q     <= '0;
            pend_f_q   <= 1'b0;
            pend_r_q   <= 1'b0;
            fdoor_q    <= 1'b0;
            rdoor_q    <= 1'b0;
            win_q      <= 1'b0;
            alarm_q    <= 1'b0;
            buzz_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bcnt_q     <= bcnt_d;
            pend_f_q   <= pend_f_d;
            pend_r_q   <= pend_r_d;
            fdoor_q    <= bus.req_fdoor;
            rdoor_q    <= bus.req_rdoor;
            win_q      <= bus.req_win;
            alarm_q    <= bus.req_alarm;
            buzz_q     <= buzz_d;
            conflict_q <= bus.req_heater & bus.req_cooler;
        end
    end

    assign bus.drv_fdoor  = (state_q == StFdoor);
    assign bus.drv_rdoor  = (state_q == StRdoor);
    assign bus.drv_heater = (state_q == StHeat);
    assign bus.drv_cooler = (state_q == StCool);
    assign bus.drv_buzz   = buzz_q;
    assign bus.conflict   = conflict_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_home_actuator_sched.sv
// Directed bench for home_actuator_sched: door pulses, HVAC min-on/lockout, alarm, beeps, reset.
module tb_home_actuator_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    home_actuator_sched_if bus ();

    home_actuator_sched #(
        .MIN_ON    (8),
        .LOCKOUT   (16),
        .DOOR_PULSE(4),
        .BEEP_HALF (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic now(input string tag, input logic [2:0] st, input logic [3:0] drv,
                       input logic bz);
        chk({tag, "/state"}, {5'd0, bus.state}, {5'd0, st});
        chk({tag, "/drv"}, {4'd0, bus.drv_fdoor, bus.drv_rdoor, bus.drv_heater, bus.drv_cooler},
            {4'd0, drv});
        chk({tag, "/buzz"}, {7'd0, bus.drv_buzz}, {7'd0, bz});
    endtask

    task automatic run(input string tag, input int n, input logic [2:0] st, input logic [3:0] drv,
                       input logic bz);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            now($sformatf("%s[%0d]", tag, i), st, drv, bz);
        end
    endtask

    task automatic chk_conf(input string tag, input logic exp);
        chk(tag, {7'd0, bus.conflict}, {7'd0, exp});
    endtask

    initial begin
        bus.req_fdoor  = 1'b0;
        bus.req_rdoor  = 1'b0;
        bus.req_heater = 1'b0;
        bus.req_cooler = 1'b0;
        bus.req_alarm  = 1'b0;
        bus.req_win    = 1'b0;

        // Reset state, then quiet idle
        repeat (2) @(negedge clk);
        now("rst", 3'd0, 4'b0000, 1'b0);
        chk_conf("rst/conflict", 1'b0);
        rst_n = 1'b1;
        run("idle20", 20, 3'd0, 4'b0000, 1'b0);

        // Request held through reset release yields exactly one pulse
        rst_n = 1'b0;
        bus.req_fdoor = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        run("hold_pend", 1, 3'd0, 4'b0000, 1'b0);
        run("hold_pulse", 4, 3'd1, 4'b1000, 1'b0);
        run("hold_after", 6, 3'd0, 4'b0000, 1'b0);
        bus.req_fdoor = 1'b0;
        run("hold_drop", 1, 3'd0, 4'b0000, 1'b0);

        // Single front-door edge, held high
        bus.req_fdoor = 1'b1;
        run("fd_pend", 1, 3'd0, 4'b0000, 1'b0);
        run("fd_pulse", 4, 3'd1, 4'b1000, 1'b0);
        run("fd_hold", 6, 3'd0, 4'b0000, 1'b0);
        bus.req_fdoor = 1'b0;
        run("fd_drop", 1, 3'd0, 4'b0000, 1'b0);

        // Both doors on the same edge
        bus.req_fdoor = 1'b1;
        bus.req_rdoor = 1'b1;
        run("both_pend", 1, 3'd0, 4'b0000, 1'b0);
        run("both_f", 4, 3'd1, 4'b1000, 1'b0);
        run("both_gap", 1, 3'd0, 4'b0000, 1'b0);
        run("both_r", 4, 3'd2, 4'b0100, 1'b0);
        run("both_end", 2, 3'd0, 4'b0000, 1'b0);
        bus.req_fdoor = 1'b0;
        bus.req_rdoor = 1'b0;
        run("both_drop", 1, 3'd0, 4'b0000, 1'b0);

        // Heater min-on with a door arriving mid-run, lockout, then door, then heater again
        bus.req_heater = 1'b1;
        run("heat_on", 2, 3'd3, 4'b0010, 1'b0);
        bus.req_fdoor = 1'b1;
        run("heat_min", 6, 3'd3, 4'b0010, 1'b0);
        run("heat_lock", 16, 3'd5, 4'b0000, 1'b0);
        run("heat_gap1", 1, 3'd0, 4'b0000, 1'b0);
        run("heat_fd", 4, 3'd1, 4'b1000, 1'b0);
        run("heat_gap2", 1, 3'd0, 4'b0000, 1'b0);
        run("heat_again", 3, 3'd3, 4'b0010, 1'b0);

        // Alarm in heat cycle 3 forces lockout and holds the buzzer
        bus.req_alarm = 1'b1;
        run("alarm_lock", 16, 3'd5, 4'b0000, 1'b1);
        run("alarm_idle", 8, 3'd0, 4'b0000, 1'b1);
        bus.req_alarm  = 1'b0;
        bus.req_heater = 1'b0;
        bus.req_fdoor  = 1'b0;
        run("alarm_off", 2, 3'd0, 4'b0000, 1'b0);

        // Window beep pattern, alarm override, restart on alarm release
        bus.req_win = 1'b1;
        run("win_h1", 4, 3'd0, 4'b0000, 1'b1);
        run("win_l1", 4, 3'd0, 4'b0000, 1'b0);
        run("win_h2", 4, 3'd0, 4'b0000, 1'b1);
        run("win_l2", 2, 3'd0, 4'b0000, 1'b0);
        bus.req_alarm = 1'b1;
        run("win_alarm", 5, 3'd0, 4'b0000, 1'b1);
        bus.req_alarm = 1'b0;
        run("win_rst_h", 4, 3'd0, 4'b0000, 1'b1);
        run("win_rst_l", 4, 3'd0, 4'b0000, 1'b0);
        bus.req_win = 1'b0;
        run("win_off", 2, 3'd0, 4'b0000, 1'b0);

        // Heater and cooler together: no grant, conflict one cycle later
        bus.req_heater = 1'b1;
        bus.req_cooler = 1'b1;
        chk_conf("conf_before", 1'b0);
        run("conf_idle", 3, 3'd0, 4'b0000, 1'b0);
        chk_conf("conf_set", 1'b1);
        bus.req_heater = 1'b0;
        bus.req_cooler = 1'b0;
        run("conf_drop", 1, 3'd0, 4'b0000, 1'b0);
        chk_conf("conf_clear", 1'b0);

        // Asynchronous reset during a door pulse clears pending flags
        bus.req_fdoor = 1'b1;
        bus.req_rdoor = 1'b1;
        run("rs_pend", 1, 3'd0, 4'b0000, 1'b0);
        run("rs_fd", 2, 3'd1, 4'b1000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        now("rs_async", 3'd0, 4'b0000, 1'b0);
        chk_conf("rs_async/conflict", 1'b0);
        bus.req_fdoor = 1'b0;
        bus.req_rdoor = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run("rs_clear", 12, 3'd0, 4'b0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
